// File: rtl/eeprom_pkg.sv
// Shared definitions for the EEPROM read/write controllers that sit in front
// of the common i2c_master: bus field widths, the R/W bit values and the
// write-controller state encoding.
package eeprom_pkg;

  localparam int SLAVE_W = 7;   // I2C 7-bit slave address
  localparam int ADDR_W  = 16;  // EEPROM memory address
  localparam int COUNT_W = 8;   // byte counts handed to i2c_master
  localparam int BYTE_W  = 8;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,      // waiting for i2c_master to report busy
    ST_ADDR_HI,    // address MSB on the bus, waiting for its request
    ST_ADDR_LO,    // address LSB on the bus
    ST_DATA,       // streaming data bytes
    ST_WAIT_STOP,  // last byte handed over, waiting for STOP
    ST_TWR         // EEPROM internal write cycle
  } wr_state_t;

endpackage

// File: rtl/write_eeprom_if.sv
// Command / byte-request interface between an EEPROM controller and the
// shared i2c_master.
//   master modport : the controller (drives address, rw, data, count, start)
//   slave modport  : the i2c_master (drives tx_data_req and busy)
interface write_eeprom_if;
  import eeprom_pkg::*;

  logic [SLAVE_W-1:0] i2c_slave_addr;
  logic               i2c_rw;
  logic [BYTE_W-1:0]  i2c_write_data;
  logic [COUNT_W-1:0] i2c_nbytes;
  logic               i2c_start;
  logic               i2c_tx_data_req;
  logic               i2c_busy;

  modport master (
    output i2c_slave_addr, i2c_rw, i2c_write_data, i2c_nbytes, i2c_start,
    input  i2c_tx_data_req, i2c_busy
  );

  modport slave (
    input  i2c_slave_addr, i2c_rw, i2c_write_data, i2c_nbytes, i2c_start,
    output i2c_tx_data_req, i2c_busy
  );
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser for a single-bit signal arriving from another clock
// domain, plus a one-cycle pulse on its (synchronised) rising edge.
//   clk   : destination clock
//   reset : asynchronous active-low reset
//   d     : asynchronous input
//   level : synchronised level (two clk of latency)
//   rise  : one-cycle pulse when level goes 0 -> 1
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [1:0] sync_q;
  logic       prev_q;

  // NOTE: non-blocking assignments so every flop samples its pre-edge input;
  // blocking here would collapse the two synchroniser stages into one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d};
      prev_q <= sync_q[1];
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~prev_q;

endmodule

// File: rtl/write_eeprom.sv
// EEPROM page-write controller. Drives i2c_master with one write transaction:
// slave address (W), 16-bit memory address MSB first, then 1..PAGE_SIZE data
// bytes taken from a show-ahead byte source, then waits the EEPROM write time.
//   clk, reset      : clock, asynchronous active-low reset
//   slave_addr_w    : 7-bit EEPROM I2C address
//   mem_addr_w      : first memory address to write
//   write_nbytes_w  : data byte count, 1..PAGE_SIZE, must not cross a page
//   start           : request, rising edge only
//   data_in         : next data byte (show-ahead)
//   byte_taken      : pulse, data_in consumed
//   busy            : accepted request in progress
//   done            : pulse, write cycle finished
//   error           : pulse, request rejected or slave NACK abort
//   i2c             : command/byte-request port to i2c_master
module write_eeprom
  import eeprom_pkg::*;
#(
  parameter int PAGE_SIZE  = 64,      // power of two
  parameter int TWR_CYCLES = 250000   // clk cycles of EEPROM write time
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SLAVE_W-1:0] slave_addr_w,
  input  logic [ADDR_W-1:0]  mem_addr_w,
  input  logic [COUNT_W-1:0] write_nbytes_w,
  input  logic               start,
  input  logic [BYTE_W-1:0]  data_in,
  output logic               byte_taken,
  output logic               busy,
  output logic               done,
  output logic               error,
  write_eeprom_if.master     i2c
);

  localparam int         PAGE_LOG2 = $clog2(PAGE_SIZE);
  localparam logic [8:0] PAGE_LIM  = 9'(PAGE_SIZE);
  localparam int         TWR_W     = (TWR_CYCLES > 1) ? $clog2(TWR_CYCLES) : 1;

  // Synchronised view of the i2c-clock-domain handshake.
  logic req_edge, req_level_unused;
  logic busy_s, busy_rise_unused;

  sync_edge u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d     (i2c.i2c_tx_data_req),
    .level (req_level_unused),
    .rise  (req_edge)
  );

  sync_edge u_busy_sync (
    .clk   (clk),
    .reset (reset),
    .d     (i2c.i2c_busy),
    .level (busy_s),
    .rise  (busy_rise_unused)
  );

  // start is a local-domain request; only its rising edge counts.
  logic start_prev_q;
  logic start_edge;
  assign start_edge = start & ~start_prev_q;

  // Page check on the raw inputs: offset within page plus count must not
  // run past the page end (9-bit sum, so no overflow for n up to 255).
  logic [8:0] page_end;
  logic       req_bad;
  assign page_end = 9'(mem_addr_w[PAGE_LOG2-1:0]) + 9'(write_nbytes_w);
  assign req_bad  = (write_nbytes_w == '0) || ({1'b0, write_nbytes_w} > PAGE_LIM)
                 || (page_end > PAGE_LIM);

  wr_state_t          state_q, state_d;
  logic [SLAVE_W-1:0] slave_q, slave_d;
  logic [7:0]         addr_lo_q, addr_lo_d;
  logic [COUNT_W-1:0] n_q, n_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic [TWR_W-1:0]   twr_q, twr_d;
  logic [BYTE_W-1:0]  wdata_q, wdata_d;
  logic [COUNT_W-1:0] nbytes_q, nbytes_d;
  logic               i2c_start_q, i2c_start_d;
  logic               busy_q, busy_d;
  logic               error_q, error_d;
  logic               taken_q, taken_d;
  logic               done_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      slave_q      <= '0;
      addr_lo_q    <= '0;
      n_q          <= '0;
      rem_q        <= '0;
      twr_q        <= '0;
      wdata_q      <= '0;
      nbytes_q     <= '0;
      i2c_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
      taken_q      <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slave_q      <= slave_d;
      addr_lo_q    <= addr_lo_d;
      n_q          <= n_d;
      rem_q        <= rem_d;
      twr_q        <= twr_d;
      wdata_q      <= wdata_d;
      nbytes_q     <= nbytes_d;
      i2c_start_q  <= i2c_start_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
      taken_q      <= taken_d;
      start_prev_q <= start;
    end
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    slave_d     = slave_q;
    addr_lo_d   = addr_lo_q;
    n_d         = n_q;
    rem_d       = rem_q;
    twr_d       = twr_q;
    wdata_d     = wdata_q;
    nbytes_d    = nbytes_q;
    i2c_start_d = i2c_start_q;
    busy_d      = busy_q;
    error_d     = 1'b0;
    taken_d     = 1'b0;
    done_c      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          slave_d   = slave_addr_w;
          addr_lo_d = mem_addr_w[7:0];
          n_d       = write_nbytes_w;
          if (req_bad) begin
            error_d = 1'b1;
          end else begin
            busy_d      = 1'b1;
            nbytes_d    = write_nbytes_w + 8'd2;
            wdata_d     = mem_addr_w[15:8];  // ready for the first request
            i2c_start_d = 1'b1;
            state_d     = ST_START;
          end
        end
      end

      ST_START: begin
        if (busy_s) begin
          i2c_start_d = 1'b0;
          state_d     = ST_ADDR_HI;
        end
      end

      // In the three byte-feeding states a falling busy means the master
      // gave up (slave NACK) before all bytes went out.
      ST_ADDR_HI: begin
        if (!busy_s) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (req_edge) begin
          wdata_d = addr_lo_q;
          state_d = ST_ADDR_LO;
        end
      end

      ST_ADDR_LO: begin
        if (!busy_s) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (req_edge) begin
          wdata_d = data_in;
          taken_d = 1'b1;
          rem_d   = n_q - 8'd1;
          state_d = (n_q == 8'd1) ? ST_WAIT_STOP : ST_DATA;
        end
      end

      ST_DATA: begin
        if (!busy_s) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (req_edge) begin
          wdata_d = data_in;
          taken_d = 1'b1;
          rem_d   = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = ST_WAIT_STOP;
        end
      end

      ST_WAIT_STOP: begin
        if (!busy_s) begin
          twr_d   = TWR_W'(TWR_CYCLES - 1);
          state_d = ST_TWR;
        end
      end

      ST_TWR: begin
        if (twr_q == '0) begin
          done_c  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          twr_d = twr_q - TWR_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign byte_taken = taken_q;
  assign busy       = busy_q;
  assign done       = done_c;
  assign error      = error_q;

  assign i2c.i2c_slave_addr = slave_q;
  assign i2c.i2c_rw         = I2C_RW_WRITE;
  assign i2c.i2c_write_data = wdata_q;
  assign i2c.i2c_nbytes     = nbytes_q;
  assign i2c.i2c_start      = i2c_start_q;

endmodule

// File: tb/tb_write_eeprom.sv
// Self-checking bench for write_eeprom: directed cases plus randomized
// requests, each checked against a page-write model of what should appear on
// the I2C side (accept/reject rule, byte stream, counts, write-time latency).
module tb_write_eeprom;
  import eeprom_pkg::*;

  localparam int PAGE       = 64;
  localparam int TWR        = 40;
  // The busy fall reaches the controller through a 2-flop synchroniser;
  // done then follows TWR clocks after the synchronised fall.
  localparam int SYNC_DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  slave_addr_w = '0;
  logic [15:0] mem_addr_w = '0;
  logic [7:0]  write_nbytes_w = '0;
  logic        start = 1'b0;
  logic [7:0]  data_in;
  logic        byte_taken, busy, done, error;

  always #5 clk = ~clk;

  write_eeprom_if bus();

  write_eeprom #(.PAGE_SIZE(PAGE), .TWR_CYCLES(TWR)) dut (
    .clk            (clk),
    .reset          (reset),
    .slave_addr_w   (slave_addr_w),
    .mem_addr_w     (mem_addr_w),
    .write_nbytes_w (write_nbytes_w),
    .start          (start),
    .data_in        (data_in),
    .byte_taken     (byte_taken),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .i2c            (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte source: show-ahead, advanced by every byte_taken pulse.
  logic [7:0] src [256];
  int bt_total = 0, bt_base = 0;
  assign data_in = src[8'(bt_total - bt_base)];

  // Event counters sampled away from the active edge.
  int   done_total = 0, err_total = 0, start_rises = 0, busy_cycles = 0;
  logic i2c_start_prev = 1'b0;

  always @(negedge clk) begin
    if (byte_taken) bt_total <= bt_total + 1;
    if (done) done_total <= done_total + 1;
    if (error) err_total <= err_total + 1;
    if (busy) busy_cycles <= busy_cycles + 1;
    if (bus.i2c_start && !i2c_start_prev) start_rises <= start_rises + 1;
    i2c_start_prev <= bus.i2c_start;
  end

  // i2c_master stand-in: takes the byte on the bus, then requests the next
  // one, for nbytes bytes; drops busy at the end (or early for a NACK).
  logic [7:0] got_bytes [$];

  task automatic i2c_model(input int nbytes, input bit nack, input bit toggle_start,
                           input int stop_at, output int lat);
    int w;
    lat = 0;
    got_bytes.delete();
    w = 0;
    while (bus.i2c_start !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (bus.i2c_start !== 1'b1) begin
      check("i2c_start_seen", {31'd0, bus.i2c_start}, 32'd1);
      return;
    end
    repeat (3) @(negedge clk);
    bus.i2c_busy = 1'b1;
    repeat (6) @(negedge clk);
    check("i2c_start_dropped", {31'd0, bus.i2c_start}, 32'd0);
    if (nack) begin
      bus.i2c_busy = 1'b0;
      return;
    end
    for (int i = 0; i < nbytes; i++) begin
      if (i == stop_at) begin
        #2 reset = 1'b0;
        return;
      end
      got_bytes.push_back(bus.i2c_write_data);
      if (toggle_start && i == 1) begin
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
      end
      if (i < nbytes - 1) begin
        bus.i2c_tx_data_req = 1'b1;
        repeat (3) @(negedge clk);
        bus.i2c_tx_data_req = 1'b0;
      end
      repeat (6) @(negedge clk);
    end
    bus.i2c_busy = 1'b0;
    while (!done && lat < TWR + 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_write(input string tag, input logic [6:0] sa, input logic [15:0] ma,
                           input logic [7:0] n, input bit nack, input bit hold,
                           input bit rand_data);
    int  lat, d0, e0, s0, b0;
    bit  accept;
    accept = (n >= 1) && (int'(n) <= PAGE) && ((int'(ma) % PAGE) + int'(n) <= PAGE);
    if (rand_data) for (int i = 0; i < 256; i++) src[i] = 8'($urandom);
    @(negedge clk);
    bt_base = bt_total;
    d0 = done_total; e0 = err_total; s0 = start_rises; b0 = busy_cycles;
    slave_addr_w = sa; mem_addr_w = ma; write_nbytes_w = n;
    start = 1'b1;
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
    if (!accept) begin
      repeat (8) @(negedge clk);
      check({tag, "_rej_error"}, err_total - e0, 1);
      check({tag, "_rej_nostart"}, start_rises - s0, 0);
      check({tag, "_rej_nobusy"}, busy_cycles - b0, 0);
      start = 1'b0;
      return;
    end
    i2c_model(int'(n) + 2, nack, hold, -1, lat);
    if (nack) begin
      repeat (TWR + 10) @(negedge clk);
      check({tag, "_nack_error"}, err_total - e0, 1);
      check({tag, "_nack_nodone"}, done_total - d0, 0);
      check({tag, "_nack_idle"}, {31'd0, busy}, 0);
      check({tag, "_nack_notaken"}, bt_total - bt_base, 0);
      start = 1'b0;
      return;
    end
    check({tag, "_latency"}, lat, TWR + SYNC_DEPTH);
    check({tag, "_nbytes"}, {24'd0, bus.i2c_nbytes}, int'(n) + 2);
    check({tag, "_slave"}, {25'd0, bus.i2c_slave_addr}, {25'd0, sa});
    check({tag, "_rw"}, {31'd0, bus.i2c_rw}, 0);
    check({tag, "_nbytes_seen"}, got_bytes.size(), int'(n) + 2);
    if (got_bytes.size() == int'(n) + 2) begin
      check({tag, "_addr_hi"}, {24'd0, got_bytes[0]}, {24'd0, ma[15:8]});
      check({tag, "_addr_lo"}, {24'd0, got_bytes[1]}, {24'd0, ma[7:0]});
      for (int k = 0; k < int'(n); k++)
        check({tag, "_data"}, {24'd0, got_bytes[k+2]}, {24'd0, src[k]});
    end
    repeat (2) @(negedge clk);
    check({tag, "_taken"}, bt_total - bt_base, int'(n));
    check({tag, "_err"}, err_total - e0, 0);
    if (hold) begin
      repeat (10) @(negedge clk);
      check({tag, "_one_start"}, start_rises - s0, 1);
      start = 1'b0;
    end
    check({tag, "_done"}, done_total - d0, 1);
    check({tag, "_busy_end"}, {31'd0, busy}, 0);
  endtask

  initial begin
    int lat, sel;
    logic [15:0] ma;
    logic [7:0]  n;
    bus.i2c_tx_data_req = 1'b0;
    bus.i2c_busy = 1'b0;
    for (int i = 0; i < 256; i++) src[i] = 8'($urandom);

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_error", {31'd0, error}, 0);
    check("rst_taken", {31'd0, byte_taken}, 0);
    check("rst_i2c_start", {31'd0, bus.i2c_start}, 0);
    check("rst_nbytes", {24'd0, bus.i2c_nbytes}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal transaction with fixed data.
    src[0] = 8'hA5;
    src[1] = 8'h3C;
    run_write("nominal", 7'h50, 16'hF0C0, 8'd2, 1'b0, 1'b0, 1'b0);

    // Page boundary and count limits.
    run_write("cross", 7'h50, 16'h003E, 8'd3, 1'b0, 1'b0, 1'b1);
    run_write("fullpage", 7'h51, 16'h0000, 8'd64, 1'b0, 1'b0, 1'b1);
    run_write("n0", 7'h50, 16'h0100, 8'd0, 1'b0, 1'b0, 1'b1);
    run_write("n65", 7'h50, 16'h0100, 8'd65, 1'b0, 1'b0, 1'b1);

    // Slave NACK, then a fresh request must be accepted.
    run_write("nack", 7'h52, 16'h1234, 8'd4, 1'b1, 1'b0, 1'b1);
    run_write("after_nack", 7'h52, 16'h1200, 8'd3, 1'b0, 1'b0, 1'b1);

    // start held high and re-pulsed while busy.
    run_write("held", 7'h53, 16'h4000, 8'd5, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of the data phase.
    @(negedge clk);
    bt_base = bt_total;
    slave_addr_w = 7'h54; mem_addr_w = 16'h0200; write_nbytes_w = 8'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    i2c_model(10, 1'b0, 1'b0, 4, lat);
    #1;
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_i2c_start", {31'd0, bus.i2c_start}, 0);
    check("mid_rst_wdata", {24'd0, bus.i2c_write_data}, 0);
    check("mid_rst_nbytes", {24'd0, bus.i2c_nbytes}, 0);
    check("mid_rst_slave", {25'd0, bus.i2c_slave_addr}, 0);
    check("mid_rst_pulses", {29'd0, done, error, byte_taken}, 0);
    bus.i2c_busy = 1'b0;
    bus.i2c_tx_data_req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_write("post_rst", 7'h54, 16'h0300, 8'd1, 1'b0, 1'b0, 1'b1);

    // Randomized requests.
    for (int it = 0; it < 16; it++) begin
      sel = $urandom_range(0, 3);
      ma = 16'($urandom);
      case (sel)
        0: begin
          n = 8'($urandom_range(1, 8));
          ma[5:0] = 6'($urandom_range(0, PAGE - 8));
        end
        1: n = ($urandom_range(0, 1) == 1) ? 8'd0 : 8'($urandom_range(65, 255));
        2: begin
          n = 8'($urandom_range(1, 6));
          ma[5:0] = 6'($urandom_range(PAGE - 6, PAGE - 1));
        end
        default: n = 8'($urandom_range(1, 64));
      endcase
      run_write("rand", 7'($urandom), ma, n, 1'b0, 1'b0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/write_eeprom.md
Name: write_eeprom

Overview:
- Write-side companion to the EEPROM read controller; drives the shared i2c_master through its command/tx_data_req interface.
- Performs one page write: slave address (W), 16-bit memory address (MSB first), then 1..PAGE_SIZE data bytes pulled from a show-ahead byte source.
- After the STOP it waits the EEPROM internal write-cycle time before reporting done.
- Sits beside read_eeprom; a top-level mux selects which controller owns i2c_master.

Parameters:
- PAGE_SIZE, 64, EEPROM page size in bytes; must be a power of two.
- TWR_CYCLES, 250000, clk cycles to wait after STOP (5 ms at 50 MHz).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- slave_addr_w  input  7  EEPROM 7-bit I2C address
- mem_addr_w  input  16  first memory address to write
- write_nbytes_w  input  8  number of data bytes, 1..PAGE_SIZE
- start  input  1  request; acted on at its rising edge only
- data_in  input  8  next data byte (show-ahead)
- byte_taken  output  1  one-cycle pulse: data_in consumed, advance source
- busy  output  1  high from accept until done or error
- done  output  1  one-cycle pulse: write cycle complete
- error  output  1  one-cycle pulse: request rejected
- i2c_slave_addr  output  7  to i2c_master addr_in
- i2c_rw  output  1  to i2c_master rw_in; constant 0
- i2c_write_data  output  8  to i2c_master write_data
- i2c_nbytes  output  8  to i2c_master nbytes_in; equals write_nbytes + 2
- i2c_start  output  1  to i2c_master start
- i2c_tx_data_req  input  1  from i2c_master; byte request
- i2c_busy  input  1  from i2c_master busy

Behaviour:
- Reset (async, active-low): all outputs 0; state IDLE; counters cleared. Reset mid-transaction returns to IDLE immediately with i2c_start low. The EEPROM may then be left mid-write; the caller is responsible.
- i2c_tx_data_req and i2c_busy come from the divided i2c clock. Each passes through a 2-flop synchroniser. tx_data_req is rising-edge detected after sync (req_edge).
- start is rising-edge detected. An edge while busy=1 is ignored.
- IDLE: on start edge, latch slave_addr_w, mem_addr_w and write_nbytes_w.
  - Check: n==0, n>PAGE_SIZE, or (mem_addr[log2(PAGE_SIZE)-1:0] + n) > PAGE_SIZE (page crossing; 9-bit add). On failure, pulse error next cycle and stay IDLE; busy stays 0.
  - Otherwise: busy=1, i2c_nbytes = n+2, i2c_write_data = mem_addr[15:8], go to START.
- START: hold i2c_start=1 until synced i2c_busy=1, then drop i2c_start and go to ADDR_HI.
- ADDR_HI: on req_edge, i2c_write_data <= mem_addr[7:0]; go to ADDR_LO. The MSB is already preloaded for the first request.
- ADDR_LO: on req_edge, i2c_write_data <= data_in; pulse byte_taken; remaining = n-1. Go to DATA, or to WAIT_STOP if remaining==0.
- DATA: on each req_edge, i2c_write_data <= data_in; pulse byte_taken; decrement remaining. At 0 go to WAIT_STOP.
  - Exactly n byte_taken pulses per transaction.
- WAIT_STOP: when synced i2c_busy falls to 0, load twr counter = TWR_CYCLES-1 and go to TWR.
  - If i2c_busy falls in any earlier active state (NACK abort), pulse error, clear busy, go to IDLE.
- TWR: decrement each clk. At 0: pulse done, clear busy, go to IDLE.
- start edge coincident with done is ignored (busy still 1 that cycle).
- No wrap-around within a page; crossing requests are rejected, never split.

Decomposition:
- Shared package (eeprom_pkg): state encoding localparams, I2C_RW_WRITE=0, I2C_RW_READ=1, address/count widths. Also used by read_eeprom.
- One sub-module: sync_edge (2-flop synchroniser plus rising-edge pulse). Instantiate it for tx_data_req and for busy (level output used). read_eeprom can reuse it.

Test Plan:
- Nominal: slave 0x50, mem 0xF0C0, n=2, data 0xA5,0x3C. Required:
  - i2c_nbytes=4.
  - Bytes presented in order 0xF0,0xC0,0xA5,0x3C.
  - 2 byte_taken pulses.
  - done exactly TWR_CYCLES clk after i2c_busy falls.
- Page check: mem 0x003E, n=3 -> error pulse, i2c_start never asserted. mem 0x0000, n=64 -> accepted, 64 byte_taken pulses.
- n=0 and n=65 -> error pulse, busy stays 0.
- Slave NACK: model drops i2c_busy after the address byte -> error pulse, no done, returns to IDLE; a new start is accepted.
- Start held high during the transaction and reasserted while busy -> exactly one transaction, one done.
- Reset asserted in DATA state -> all outputs 0 asynchronously. After release, a new write of n=1 completes normally.
